// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_pkg                                                          |
// | Shared CPU types: opcodes, ALU ops, fetch FSM states, constants. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package cpu_pkg;

   localparam logic [31:0] c_NOP = 32'h0000_0013;

   typedef enum logic [6:0] {
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_BRANCH = 7'b1100011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_IMM    = 7'b0010011,
      OP_REG    = 7'b0110011
   } opcode_t;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
   } alu_op_t;

   typedef enum logic [1:0] {
      FS_IDLE  = 2'd0,
      FS_FETCH = 2'd1,
      FS_FLUSH = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_fifo                                                       |
// | DEPTH-entry {pc,data} instruction buffer with synchronous flush. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  fetch_entry_t               push_data,
   input  logic                       pop,
   output fetch_entry_t               pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = $clog2(DEPTH + 1);

   fetch_entry_t    r_mem [DEPTH];
   logic [c_AW-1:0] r_rd_ptr;
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_CW-1:0] r_count;
   logic            w_do_push;
   logic            w_do_pop;

   assign empty     = (r_count == '0);
   assign full      = (r_count == c_CW'(DEPTH));
   assign count     = r_count;
   assign pop_data  = r_mem[r_rd_ptr];
   assign w_do_pop  = pop && !empty;
   // A full buffer still takes a push when the head leaves in the same cycle
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
            r_wr_ptr        <= r_wr_ptr + c_AW'(1);
         end
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + c_AW'(1);
         r_count <= r_count + c_CW'(w_do_push) - c_CW'(w_do_pop);
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_unit                                                       |
// | Credit-limited instruction fetch with redirect/flush handling.   |
// | Optional macro FETCH_PERF_CNT_EN adds the stall_cycles counter.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst_pc,
   output logic [31:0] inst_data,
   input  logic        inst_ready
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   localparam int c_CW = $clog2(DEPTH + 1);
   localparam int c_SW = c_CW + 1;

   fetch_state_t    r_state;
   fetch_state_t    w_state_next;
   logic [31:0]     r_fetch_pc;
   logic [31:0]     w_pc_next;
   logic [31:0]     r_target_pc;
   logic [31:0]     r_rsp_pc;
   logic            r_req_valid;
   logic            w_req_valid_next;
   logic [c_CW-1:0] r_outstanding;
   logic [c_CW-1:0] w_out_next;
   logic [c_CW-1:0] w_occ_next;
   logic [c_SW-1:0] w_credit_sum;
   logic [c_CW-1:0] w_fifo_count;
   logic [31:0]     w_redirect_pc;
   logic            w_accept;
   logic            w_req_hold;
   logic            w_drop;
   logic            w_push;
   logic            w_pop;
   logic            w_fifo_full;
   logic            w_fifo_empty;
   fetch_entry_t    w_head;

   assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
   assign w_accept      = r_req_valid && imem_req_ready;
   assign w_req_hold    = r_req_valid && !imem_req_ready;
   // Responses belong to the old stream in the redirect cycle and throughout FLUSH
   assign w_drop        = redirect_valid || (r_state == FS_FLUSH);
   assign w_pop         = inst_valid && inst_ready;
   assign w_push        = imem_rsp_valid && !w_drop && (!w_fifo_full || w_pop);

   assign imem_req_valid = r_req_valid;
   assign imem_req_addr  = r_fetch_pc;
   assign inst_valid     = !w_fifo_empty;
   assign inst_pc        = w_head.pc;
   assign inst_data      = w_head.data;

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (w_push),
      .push_data ({r_rsp_pc, imem_rsp_data}),
      .pop       (w_pop),
      .pop_data  (w_head),
      .full      (w_fifo_full),
      .empty     (w_fifo_empty),
      .count     (w_fifo_count)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= FS_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_out_next = r_outstanding;
      if (w_accept) w_out_next = w_out_next + c_CW'(1);
      if (imem_rsp_valid && (r_outstanding != '0)) w_out_next = w_out_next - c_CW'(1);

      if (redirect_valid) w_occ_next = '0;
      else                w_occ_next = w_fifo_count + c_CW'(w_push) - c_CW'(w_pop);
      w_credit_sum = {1'b0, w_out_next} + {1'b0, w_occ_next};

      w_state_next = r_state;
      case (r_state)
         FS_IDLE:  w_state_next = FS_FETCH;
         FS_FETCH: w_state_next = FS_FETCH;
         FS_FLUSH: if ((w_out_next == '0) && !w_req_hold) w_state_next = FS_FETCH;
         default:  w_state_next = FS_IDLE;
      endcase
      if (redirect_valid) begin
         if ((r_state != FS_FLUSH) && (r_outstanding == '0) && !r_req_valid)
            w_state_next = FS_FETCH;
         else
            w_state_next = FS_FLUSH;
      end

      w_pc_next = r_fetch_pc;
      if (w_accept) w_pc_next = r_fetch_pc + 32'd4;
      if (redirect_valid && (w_state_next == FS_FETCH))
         w_pc_next = w_redirect_pc;
      else if ((r_state == FS_FLUSH) && (w_state_next == FS_FETCH))
         w_pc_next = r_target_pc;

      // A request once raised stays up until accepted, whatever the state does
      if (w_req_hold) w_req_valid_next = 1'b1;
      else            w_req_valid_next = (w_state_next == FS_FETCH) &&
                                         (w_credit_sum < c_SW'(DEPTH));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_pc    <= RESET_PC;
         r_target_pc   <= RESET_PC;
         r_rsp_pc      <= RESET_PC;
         r_req_valid   <= 1'b0;
         r_outstanding <= '0;
      end else begin
         r_fetch_pc    <= w_pc_next;
         r_req_valid   <= w_req_valid_next;
         r_outstanding <= w_out_next;
         if (redirect_valid) begin
            r_target_pc <= w_redirect_pc;
            r_rsp_pc    <= w_redirect_pc;
         end else if (w_push) begin
            r_rsp_pc    <= r_rsp_pc + 32'd4;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_stall_cycles;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_stall_cycles <= '0;
      else if ((r_state != FS_IDLE) && !inst_valid && (r_stall_cycles != 32'hFFFF_FFFF))
         r_stall_cycles <= r_stall_cycles + 32'd1;
   end

   assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fetch_unit                                                    |
// | Directed + randomized bench with a transaction-level fetch model.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_fetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst_pc;
   logic [31:0] inst_data;
   logic        inst_ready;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cycles;
`endif

   fetch_unit #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_pc        (inst_pc),
      .inst_data      (inst_data),
      .inst_ready     (inst_ready)
`ifdef FETCH_PERF_CNT_EN
      ,
      .stall_cycles   (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          tag;
      int          due;
   } mreq_t;

   mreq_t       memq[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          rel_cyc = 0;
   int          first_cyc = -1;
   int          n_acc = 0;
   int          epoch = 0;
   int          occ = 0;
   logic [31:0] exp_req = RESET_PC;
   logic [31:0] exp_ipc = RESET_PC;
   bit          old_pending = 0;
   bit          prev_hold = 0;
   logic [31:0] prev_addr = '0;
   bit          prev_istall = 0;
   logic [31:0] prev_ipc = '0;
   logic [31:0] prev_idata = '0;
   logic [31:0] watch_pc = '0;
   bit          got = 0;
   bit          saw80 = 0;
   int          rdy_pct = 100;
   int          irdy_pct = 100;
   int          rsp_pct = 100;
   int          lat_min = 1;
   int          lat_max = 1;
   int          stall_exp = 0;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'h5A5A_0000 ^ {a[15:0], a[31:16]};
   endfunction

   function automatic int stale_outstanding();
      int n = 0;
      foreach (memq[i]) if (memq[i].tag != epoch) n++;
      return n;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic process();
      mreq_t       e;
      logic [31:0] tgt;
      if (!reset) begin
         chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
         chk("rst_req_addr", {32'd0, imem_req_addr}, {32'd0, RESET_PC});
         chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
         chk("rst_inst_pc", {32'd0, inst_pc}, 64'd0);
         chk("rst_inst_data", {32'd0, inst_data}, 64'd0);
`ifdef FETCH_PERF_CNT_EN
         chk("rst_stall_cycles", {32'd0, stall_cycles}, 64'd0);
`endif
         memq.delete();
         epoch = 0; occ = 0; old_pending = 0;
         exp_req = RESET_PC; exp_ipc = RESET_PC;
         prev_hold = 0; prev_istall = 0; stall_exp = 0;
         return;
      end

`ifdef FETCH_PERF_CNT_EN
      chk("stall_cycles", {32'd0, stall_cycles}, 64'(stall_exp));
      if (cyc != rel_cyc && !inst_valid) stall_exp++;
`endif

      if (cyc == rel_cyc) chk("idle_no_req", {63'd0, imem_req_valid}, 64'd0);
      if (prev_hold) begin
         chk("req_hold_valid", {63'd0, imem_req_valid}, 64'd1);
         chk("req_hold_addr", {32'd0, imem_req_addr}, {32'd0, prev_addr});
      end else if (imem_req_valid) begin
         chk("req_credit", 64'(memq.size() + occ < DEPTH), 64'd1);
         chk("req_after_drain", 64'(stale_outstanding()), 64'd0);
      end

      if (prev_istall) begin
         chk("inst_hold_valid", {63'd0, inst_valid}, 64'd1);
         chk("inst_hold_pc", {32'd0, inst_pc}, {32'd0, prev_ipc});
         chk("inst_hold_data", {32'd0, inst_data}, {32'd0, prev_idata});
      end
      chk("inst_valid_occ", {63'd0, inst_valid}, 64'(occ > 0));
      if (inst_valid && first_cyc < 0) first_cyc = cyc;
      if (inst_valid && inst_pc == 32'h80) saw80 = 1;
      if (inst_valid && inst_ready) begin
         chk("inst_pc", {32'd0, inst_pc}, {32'd0, exp_ipc});
         chk("inst_data", {32'd0, inst_data}, {32'd0, mdata(exp_ipc)});
         if (inst_pc == watch_pc) got = 1;
         exp_ipc += 32'd4;
         if (occ > 0) occ--;
      end

      if (imem_rsp_valid && memq.size() > 0) begin
         e = memq.pop_front();
         if (e.tag == epoch && !redirect_valid) occ++;
      end

      if (imem_req_valid && imem_req_ready) begin
         n_acc++;
         if (old_pending) begin
            old_pending = 0;
            e.tag = -1;
         end else begin
            chk("req_addr", {32'd0, imem_req_addr}, {32'd0, exp_req});
            exp_req += 32'd4;
            e.tag = epoch;
         end
         e.addr = imem_req_addr;
         e.due  = cyc + int'($urandom_range(lat_max, lat_min));
         memq.push_back(e);
      end

      if (redirect_valid) begin
         tgt = {redirect_pc[31:2], 2'b00};
         epoch++;
         occ = 0;
         exp_req = tgt;
         exp_ipc = tgt;
         old_pending = imem_req_valid && !imem_req_ready;
      end

      prev_hold   = imem_req_valid && !imem_req_ready;
      prev_addr   = imem_req_addr;
      prev_istall = inst_valid && !inst_ready && !redirect_valid;
      prev_ipc    = inst_pc;
      prev_idata  = inst_data;
   endtask

   task automatic drive(input bit redir, input logic [31:0] tgt);
      imem_req_ready = ($urandom_range(99) < rdy_pct);
      inst_ready     = ($urandom_range(99) < irdy_pct);
      redirect_valid = redir;
      redirect_pc    = redir ? tgt : $urandom;
      if (memq.size() > 0 && memq[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mdata(memq[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      @(negedge clk);
      process();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic step();
      drive(1'b0, 32'h0);
   endtask

   task automatic step_redir(input logic [31:0] tgt);
      drive(1'b1, tgt);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
      rel_cyc   = cyc;
      first_cyc = -1;
      n_acc     = 0;
   endtask

   task automatic wait_pop(input logic [31:0] pc, input int bound, input string tag);
      int n = 0;
      watch_pc = pc;
      got = 0;
      while (!got && n < bound) begin
         step();
         n++;
      end
      chk(tag, {63'd0, got}, 64'd1);
   endtask

   task automatic wait_outstanding(input int want, input int bound);
      int n = 0;
      while (memq.size() != want && n < bound) begin
         step();
         n++;
      end
      chk("reach_outstanding", 64'(memq.size()), 64'(want));
   endtask

   initial begin
      reset = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
      @(posedge clk);
      #1;

      // Streaming from reset: single-cycle memory, decode always ready
      do_reset();
      repeat (12) step();
      chk("first_valid_latency", 64'(first_cyc - rel_cyc), 64'd3);
      chk("stream_accepts", 64'(n_acc), 64'd11);

      // Decode stalled: only DEPTH requests may be in flight or buffered
      do_reset();
      irdy_pct = 0;
      repeat (20) step();
      chk("stall_accepts", 64'(n_acc), 64'(DEPTH));
      chk("stall_req_valid", {63'd0, imem_req_valid}, 64'd0);
      chk("stall_head_pc", {32'd0, inst_pc}, 64'h0);
      irdy_pct = 100;
      wait_pop(32'h0000_000C, 10, "stall_drain_c");

      // Redirect with two requests outstanding
      do_reset();
      lat_min = 3; lat_max = 3;
      wait_outstanding(2, 20);
      step_redir(32'h0000_0040);
      wait_pop(32'h0000_0040, 40, "redir_40");

      // Second redirect while the first is still flushing
      do_reset();
      saw80 = 0;
      wait_outstanding(2, 20);
      step_redir(32'h0000_0080);
      step();
      step_redir(32'h0000_0100);
      wait_pop(32'h0000_0100, 40, "redir_100");
      chk("no_pc_80", {63'd0, saw80}, 64'd0);

      // Memory stalls five cycles with a redirect in the second; low bits ignored
      do_reset();
      lat_min = 1; lat_max = 2;
      repeat (6) step();
      rdy_pct = 0;
      step();
      step_redir(32'h0000_0203);
      repeat (3) step();
      rdy_pct = 100;
      wait_pop(32'h0000_0200, 40, "redir_200");

      // Address wrap at the top of the space
      step_redir(32'hFFFF_FFF8);
      wait_pop(32'h0000_0000, 40, "pc_wrap");

      // Randomized traffic with occasional redirects
      do_reset();
      for (int blk = 0; blk < 15; blk++) begin
         rdy_pct  = int'($urandom_range(100, 30));
         irdy_pct = int'($urandom_range(100, 20));
         rsp_pct  = int'($urandom_range(100, 40));
         lat_min  = 1;
         lat_max  = int'($urandom_range(4, 1));
         for (int k = 0; k < 200; k++) begin
            if ($urandom_range(99) < 3) step_redir($urandom);
            else                        step();
         end
      end
      rdy_pct = 100; irdy_pct = 100; rsp_pct = 100; lat_max = 1;
      step_redir(32'h0000_1000);
      wait_pop(32'h0000_1010, 60, "random_tail");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, instruction buffer entries plus outstanding-request credit limit (power of 2, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 imem_req_valid  out  1  fetch request valid.
REQ-006 imem_req_addr  out  32  word-aligned fetch address.
REQ-007 imem_req_ready  in  1  memory accepts request this cycle.
REQ-008 imem_rsp_valid  in  1  response word valid (in order, >=1 cycle after accept).
REQ-009 imem_rsp_data  in  32  instruction word.
REQ-010 redirect_valid  in  1  taken branch/jal/jalr from execute stage.
REQ-011 redirect_pc  in  32  new fetch target.
REQ-012 inst_valid / inst_pc / inst_data  out  1/32/32  head of buffer to decode.
REQ-013 inst_ready  in  1  decode consumes head this cycle.

Function
REQ-014 States: IDLE, FETCH, FLUSH; IDLE lasts exactly one cycle after reset release, then FETCH.
REQ-015 Request handshake completes on imem_req_valid && imem_req_ready; fetch_pc advances by 4 on completion, wraps modulo 2^32.
REQ-016 imem_req_valid and imem_req_addr SHALL hold stable until accepted; no withdrawal, including on redirect.
REQ-017 In FETCH, imem_req_valid asserts only when outstanding + buffer occupancy < DEPTH.
REQ-018 Accepted response written to buffer with its pc; visible on inst_valid the cycle after imem_rsp_valid (no bypass).
REQ-019 Simultaneous accept-response and inst_ready pop on a full buffer SHALL both complete.
REQ-020 Output handshake completes on inst_valid && inst_ready; inst_pc/inst_data stable while inst_valid && !inst_ready.
REQ-021 redirect_valid (any state): buffer flushed next cycle, target pc latched; responses arriving that cycle or later for old requests are dropped.
REQ-022 Redirect with outstanding == 0 and no pending unaccepted request: next state FETCH, first request at redirect_pc next cycle.
REQ-023 Otherwise next state FLUSH; pending request completes normally, then all outstanding responses are dropped; FLUSH -> FETCH when outstanding reaches 0.
REQ-024 Redirect during FLUSH replaces target pc; remains FLUSH.
REQ-025 Redirect coincident with an inst_ready handshake: handshake counts as transferred, buffer still flushed.
REQ-026 redirect_pc[1:0] forced to 2'b00.
REQ-027 Outstanding counter width ceil(log2(DEPTH+1)); never exceeds DEPTH.

Reset
REQ-028 While reset low: state IDLE, fetch_pc RESET_PC, buffer empty, outstanding 0.
REQ-029 Reset values: imem_req_valid 0, imem_req_addr RESET_PC, inst_valid 0, inst_pc 0, inst_data 0.
REQ-030 Reset asserted mid-transaction discards all in-flight state; post-reset responses from prior requests are the memory's responsibility.

Configuration
REQ-031 Macro FETCH_PERF_CNT_EN defined: adds output stall_cycles (32 bit), incrementing each cycle inst_valid == 0 outside IDLE, reset to 0, saturating at 32'hFFFF_FFFF.
REQ-032 Macro undefined: port and counter absent; all other behaviour identical.

Structure
REQ-033 fetch_state_t and the NOP constant 32'h0000_0013 belong in shared package cpu_pkg alongside existing opcode/ALU enums.
REQ-034 Buffer implemented as sub-module fetch_fifo (DEPTH x 64-bit {pc,data}, push/pop/full/empty/count).

Verification
REQ-035 Reset release, memory always ready, 1-cycle latency -> requests 0x0,0x4,0x8,...; first inst_valid 3 cycles after reset release with inst_pc 0x0.
REQ-036 inst_ready held 0, DEPTH=4 -> exactly 4 requests accepted, imem_req_valid drops; buffer holds pcs 0x0..0xC.
REQ-037 Redirect to 0x40 with 2 outstanding -> FLUSH, both responses dropped, next request 0x40, first inst_pc 0x40.
REQ-038 Redirect to 0x80 then 0x100 during FLUSH -> fetch resumes at 0x100, no instruction with pc 0x80 delivered.
REQ-039 imem_req_ready low 5 cycles with redirect in cycle 2 -> addr stable all 5 cycles, that response dropped.
REQ-040 FETCH_PERF_CNT_EN defined, inst_ready 1, memory latency 3 -> stall_cycles matches model count; macro undefined -> build has no stall_cycles port.
